// File: rtl/udp_parser_pkg.sv
// Shared types for the 40G UDP parser statistics blocks.
// Running-max table entry and sample/counter widths.
package udp_parser_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [31:0]      max;
    logic [CNT_W-1:0] cnt;
  } max_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/udp_max_tracker_if.sv
// Requester, result, clear and host-read signals of the max tracker.
// Master drives samples and host commands; slave is the tracker.
interface udp_max_tracker_if #(
  parameter int NUM_REQ = 4
);
  import udp_parser_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      res_valid;
  logic [ID_W-1:0]           res_id;
  logic [DATA_W-1:0]         res_max;
  logic                      res_new;

  logic                      clr_en;
  logic [ID_W-1:0]           clr_id;

  logic                      rd_en;
  logic [ID_W-1:0]           rd_id;
  logic                      rd_valid;
  logic [DATA_W-1:0]         rd_max;
  logic [CNT_W-1:0]          rd_cnt;

  modport master (
    output req_valid, req_data,
    output clr_en, clr_id, rd_en, rd_id,
    input  req_ready,
    input  res_valid, res_id, res_max, res_new,
    input  rd_valid, rd_max, rd_cnt
  );

  modport slave (
    input  req_valid, req_data,
    input  clr_en, clr_id, rd_en, rd_id,
    output req_ready,
    output res_valid, res_id, res_max, res_new,
    output rd_valid, rd_max, rd_cnt
  );

endinterface

// File: rtl/udp_max_tracker_max_cal.sv
// Shared 32-bit max comparator.
// gt flags that b strictly exceeds a.
module max_cal (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] max,
  output logic        gt
);

  assign gt  = b > a;
  assign max = gt ? b : a;

endmodule

// File: rtl/udp_max_tracker.sv
// Per-channel running-max table fed by a round-robin arbiter.
// One shared comparator performs a single-cycle read-modify-write.
module udp_max_tracker
  import udp_parser_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic             clk,
  input logic             rst,
  udp_max_tracker_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               acc;
  logic [NUM_REQ-1:0] gnt;
  max_entry_t         tbl [NUM_REQ];
  max_entry_t         base;
  logic [DATA_W-1:0]  sample;
  logic [DATA_W-1:0]  new_max;
  logic               new_gt;

  always_comb begin
    logic [ID_W-1:0] idx;
    gnt_id = '0;
    acc    = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + k[ID_W-1:0];
      if (!acc && bus.req_valid[idx]) begin
        acc    = 1'b1;
        gnt_id = idx;
      end
    end
    if (rst) acc = 1'b0;
    gnt = '0;
    if (acc) gnt[gnt_id] = 1'b1;
  end

  assign bus.req_ready = gnt;

  // a same-cycle clear of the granted entry is folded in before compare
  always_comb begin
    base = tbl[gnt_id];
    if (bus.clr_en && bus.clr_id == gnt_id)
      base = '0;
  end

  assign sample = bus.req_data[gnt_id*DATA_W +: DATA_W];

  max_cal u_max_cal (
    .a   (base.max),
    .b   (sample),
    .max (new_max),
    .gt  (new_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        tbl[i] <= '0;
    end else begin
      if (acc) ptr <= gnt_id + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc && gnt_id == i[ID_W-1:0]) begin
          tbl[i].max <= new_max;
          tbl[i].cnt <= sat_inc(base.cnt);
        end else if (bus.clr_en && bus.clr_id == i[ID_W-1:0]) begin
          tbl[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_max   <= '0;
      bus.res_new   <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_max    <= '0;
      bus.rd_cnt    <= '0;
    end else begin
      bus.res_valid <= acc;
      if (acc) begin
        bus.res_id  <= gnt_id;
        bus.res_max <= new_max;
        bus.res_new <= new_gt;
      end
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_max <= tbl[bus.rd_id].max;
        bus.rd_cnt <= tbl[bus.rd_id].cnt;
      end
    end
  end

endmodule

// File: tb/tb_udp_max_tracker.sv
// Directed bench for udp_max_tracker.
// Hand-computed expectations for arbitration, update, clear and read.
module tb_udp_max_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  udp_max_tracker_if #(.NUM_REQ(4)) bus();

  udp_max_tracker #(.NUM_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    bus.req_data[i*32 +: 32] = v;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] id,
                        input logic [31:0] emax, input logic [15:0] ecnt);
    bus.rd_en = 1'b1;
    bus.rd_id = id;
    tick();
    bus.rd_en = 1'b0;
    chk({tag, "_v"}, 64'(bus.rd_valid), 64'd1);
    chk({tag, "_max"}, 64'(bus.rd_max), 64'(emax));
    chk({tag, "_cnt"}, 64'(bus.rd_cnt), 64'(ecnt));
  endtask

  task automatic res_chk(input string tag, input logic [1:0] id,
                         input logic [31:0] emax, input logic enew);
    chk({tag, "_v"}, 64'(bus.res_valid), 64'd1);
    chk({tag, "_id"}, 64'(bus.res_id), 64'(id));
    chk({tag, "_max"}, 64'(bus.res_max), 64'(emax));
    chk({tag, "_new"}, 64'(bus.res_new), 64'(enew));
  endtask

  logic [31:0] s2 [3];
  logic [3:0]  oh;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.clr_en    = 1'b0;
    bus.clr_id    = '0;
    bus.rd_en     = 1'b0;
    bus.rd_id     = '0;

    // 1: reset
    bus.req_valid = 4'hF;
    tick();
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resv", 64'(bus.res_valid), 64'd0);
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
    rd_chk("rst_rd0", 2'd0, 32'd0, 16'd0);

    // 2: id1 samples 10,5,20
    s2[0] = 32'd10; s2[1] = 32'd5; s2[2] = 32'd20;
    bus.req_valid = 4'b0010;
    set_data(1, s2[0]);
    #1 chk("t2_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    res_chk("t2_a", 2'd1, 32'd10, 1'b1);
    set_data(1, s2[1]);
    tick();
    res_chk("t2_b", 2'd1, 32'd10, 1'b0);
    set_data(1, s2[2]);
    tick();
    res_chk("t2_c", 2'd1, 32'd20, 1'b1);
    bus.req_valid = '0;
    #1 chk("t2_noreq", 64'(bus.req_ready), 64'd0);
    rd_chk("t2_rd1", 2'd1, 32'd20, 16'd3);

    // pointer is 2; one accept on id3 moves it to 0
    bus.req_valid = 4'b1000;
    set_data(3, 32'd7);
    tick();
    res_chk("t3_pre", 2'd3, 32'd7, 1'b1);

    // 3: all valid, round robin from 0
    for (int i = 0; i < 4; i++) set_data(i, 32'd100 + i);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      oh = 4'b0001 << (k % 4);
      #1 chk($sformatf("t3_rdy%0d", k), 64'(bus.req_ready), 64'(oh));
      tick();
      chk($sformatf("t3_id%0d", k), 64'(bus.res_id), 64'(k % 4));
      chk($sformatf("t3_v%0d", k), 64'(bus.res_valid), 64'd1);
    end
    bus.req_valid = '0;
    rd_chk("t3_rd0", 2'd0, 32'd100, 16'd2);
    rd_chk("t3_rd1", 2'd1, 32'd101, 16'd5);
    rd_chk("t3_rd3", 2'd3, 32'd103, 16'd3);

    // 4: id2 to 50, then clear + accept 30 on id2
    bus.clr_en = 1'b1;
    bus.clr_id = 2'd2;
    tick();
    bus.clr_en = 1'b0;
    bus.req_valid = 4'b0100;
    set_data(2, 32'd50);
    tick();
    res_chk("t4_50", 2'd2, 32'd50, 1'b1);
    set_data(2, 32'd30);
    bus.clr_en = 1'b1;
    bus.clr_id = 2'd2;
    tick();
    bus.clr_en = 1'b0;
    bus.req_valid = '0;
    res_chk("t4_clr", 2'd2, 32'd30, 1'b1);
    rd_chk("t4_rd2", 2'd2, 32'd30, 16'd1);

    // clear id0 while accepting id1, with a same-cycle read of id1
    bus.req_valid = 4'b0010;
    set_data(1, 32'd3);
    bus.clr_en = 1'b1;
    bus.clr_id = 2'd0;
    bus.rd_en  = 1'b1;
    bus.rd_id  = 2'd1;
    tick();
    bus.req_valid = '0;
    bus.clr_en = 1'b0;
    bus.rd_en  = 1'b0;
    res_chk("tx_acc", 2'd1, 32'd101, 1'b0);
    chk("tx_rdpre_max", 64'(bus.rd_max), 64'd101);
    chk("tx_rdpre_cnt", 64'(bus.rd_cnt), 64'd5);
    rd_chk("tx_rd0", 2'd0, 32'd0, 16'd0);
    rd_chk("tx_rd1", 2'd1, 32'd101, 16'd6);

    // 5: all-ones samples on id3
    bus.clr_en = 1'b1;
    bus.clr_id = 2'd3;
    tick();
    bus.clr_en = 1'b0;
    bus.req_valid = 4'b1000;
    set_data(3, 32'hFFFF_FFFF);
    tick();
    res_chk("t5_a", 2'd3, 32'hFFFF_FFFF, 1'b1);
    tick();
    res_chk("t5_b", 2'd3, 32'hFFFF_FFFF, 1'b0);
    bus.req_valid = '0;
    rd_chk("t5_rd3", 2'd3, 32'hFFFF_FFFF, 16'd2);

    // 6: reset mid-stream
    bus.req_valid = 4'b0001;
    set_data(0, 32'd9);
    tick();
    res_chk("t6_pre", 2'd0, 32'd9, 1'b1);
    rst = 1'b1;
    #1 chk("t6_rdy_rst", 64'(bus.req_ready), 64'd0);
    tick();
    chk("t6_resv", 64'(bus.res_valid), 64'd0);
    rst = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++)
      rd_chk($sformatf("t6_rd%0d", i), 2'(i), 32'd0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
